fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the hazard detector and IF/ID register.
- Owns the PC, issues single-beat requests to a variable-latency instruction memory, and holds each returned instruction until the pipeline takes it.
- Obeys the hazard detector's PC write enable (stall), takes branch/jump redirects, and stops fetching after a HALT.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, value driven on instr_out when no valid instruction is presented.
- HALT_INSTR, 16'h0000, encoding that stops fetch once consumed.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pc_write_en_in  in  1  from hazard detector; 1 = presented instruction consumed this cycle
- redirect_in  in  1  branch/jump resolved taken; overrides stall
- redirect_pc_in  in  16  redirect target; bit 0 ignored (forced 0)
- imem_en_out  out  1  request strobe, one cycle per request
- imem_addr_out  out  16  request address
- imem_done_in  in  1  response valid; may be same cycle as imem_en_out or any later cycle
- imem_data_in  in  16  instruction word, valid with imem_done_in
- instr_out  out  16  instruction for IF/ID
- pc_plus2_out  out  16  address of presented instruction + 2
- valid_out  out  1  instr_out/pc_plus2_out hold a real instruction
- halted_out  out  1  fetch stopped on HALT

Behaviour:
- Single clock domain: clk; reset synchronous, active-high (rst).
- State machine states: REQ, WAIT, WAIT_DISCARD, HAVE, HALTED.
- Registers: pc (address of the instruction being fetched or presented), instr_reg, state.
- Reset:
  - pc=RESET_PC, state=REQ.
  - During rst: imem_en_out=0, valid_out=0, instr_out=NOP_INSTR, halted_out=0.
  - Memory shares rst; no stale response can follow reset.
- Outputs:
  - valid_out = (state==HAVE).
  - instr_out = valid_out ? instr_reg : NOP_INSTR.
  - pc_plus2_out = pc+2, modulo 2^16.
  - halted_out = (state==HALTED).
  - imem_en_out is always 0 in a cycle where redirect_in=1.
- REQ:
  - imem_en_out=1, imem_addr_out=pc.
  - done same cycle: capture data, go HAVE. Otherwise go WAIT.
- WAIT:
  - imem_en_out=0.
  - On done: capture, go HAVE.
- HAVE:
  - pc_write_en_in=0: hold all outputs and pc stable.
  - pc_write_en_in=1 and instr_reg==HALT_INSTR: pc<=pc+2, go HALTED, no request issued.
  - pc_write_en_in=1 otherwise: pc<=pc+2; same cycle imem_en_out=1, imem_addr_out=pc+2.
    - Done same cycle: capture, stay HAVE (1 instr/cycle throughput).
    - Otherwise go WAIT.
- HALTED: no requests; only redirect or rst leave it.
- Redirect priority: highest after rst; pc<=target, and any captured instruction is dropped (valid_out=0 next cycle).
  - REQ: no request issued; stay REQ.
  - WAIT without done: go WAIT_DISCARD.
  - WAIT with done: drop data, go REQ.
  - WAIT_DISCARD: stay; go REQ if done.
  - HAVE/HALTED: go REQ.
- WAIT_DISCARD: on done, drop data, go REQ. A redirect here only updates pc.
- Width rules:
  - pc+2 wraps 16'hFFFE -> 16'h0000.
  - pc_write_en_in is ignored outside HAVE.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs perf_fetched_out[15:0] and perf_stall_out[15:0].
  - perf_fetched_out counts instructions consumed (HAVE && pc_write_en_in && !redirect_in).
  - perf_stall_out counts cycles in HAVE with pc_write_en_in=0.
  - Both reset to 0 and saturate at 16'hFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Zero-latency memory, pc_write_en_in=1 always, words 0x1111,0x2222,0x3333 at 0,2,4:
  - 1 cycle after reset release valid_out=1, instr_out=0x1111.
  - Then one instruction per cycle; pc_plus2_out=2,4,6.
- 3-cycle memory latency:
  - imem_en_out pulses once per request.
  - valid_out=0 with instr_out=0x0800 while waiting.
  - Instruction appears the cycle after done.
- Stall: pc_write_en_in=0 for 4 cycles while presenting 0x2222 at pc=2:
  - instr_out, pc_plus2_out=4 held; no imem_en_out.
  - Resumes with a request to address 4 in the release cycle.
- Redirect to 0x0041 while a request to 0x0006 is pending:
  - Late response dropped (valid_out stays 0).
  - Next request address 0x0040.
- HALT (0x0000) consumed at pc=8:
  - halted_out=1, no further requests.
  - Redirect to 0x0010 resumes fetch at 0x0010.
- Wrap and reset: instruction at 0xFFFE consumed -> next request 0x0000. rst asserted mid-WAIT -> pc=0, state REQ, valid_out=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - pipeline and instruction-memory signals of the fetch stage
//
// Purpose: bundles the fetch stage's hazard/redirect inputs, its instruction
// memory request/response pair and the instruction presented to IF/ID.
// Modports:
//   master - the fetch unit (drives imem request and IF/ID outputs)
//   slave  - the environment (hazard detector, branch unit, instruction memory)
// Signals:
//   pc_write_en_in   1 = presented instruction consumed this cycle
//   redirect_in      taken branch/jump, overrides stall
//   redirect_pc_in   redirect target (bit 0 ignored)
//   imem_en_out      one-cycle request strobe
//   imem_addr_out    request address
//   imem_done_in     response valid (same or later cycle)
//   imem_data_in     instruction word, valid with imem_done_in
//   instr_out        instruction for IF/ID
//   pc_plus2_out     presented address + 2
//   valid_out        instr_out/pc_plus2_out hold a real instruction
//   halted_out       fetch stopped on HALT
interface fetch_unit_if;
  logic        pc_write_en_in;
  logic        redirect_in;
  logic [15:0] redirect_pc_in;
  logic        imem_en_out;
  logic [15:0] imem_addr_out;
  logic        imem_done_in;
  logic [15:0] imem_data_in;
  logic [15:0] instr_out;
  logic [15:0] pc_plus2_out;
  logic        valid_out;
  logic        halted_out;

  modport master (
    input  pc_write_en_in, redirect_in, redirect_pc_in, imem_done_in, imem_data_in,
    output imem_en_out, imem_addr_out, instr_out, pc_plus2_out, valid_out, halted_out
  );

  modport slave (
    output pc_write_en_in, redirect_in, redirect_pc_in, imem_done_in, imem_data_in,
    input  imem_en_out, imem_addr_out, instr_out, pc_plus2_out, valid_out, halted_out
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with variable-latency memory
//
// Purpose: owns the PC, issues single-beat requests to instruction memory,
// holds each returned instruction until the pipeline consumes it, follows
// stall/redirect from downstream and stops fetching after HALT.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset
//   bus   fetch_unit_if.master (see rtl/fetch_unit_if.sv)
//   perf_fetched_out[15:0], perf_stall_out[15:0]  only with FETCH_PERF_EN
// Optional feature macro: FETCH_PERF_EN adds saturating consumed-instruction
// and stall-cycle counters.
module fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'h0800,
  parameter logic [15:0] HALT_INSTR = 16'h0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]  perf_fetched_out,
  output logic [15:0]  perf_stall_out
`endif
);

  typedef enum logic [2:0] {
    REQ          = 3'd0,
    WAIT         = 3'd1,
    WAIT_DISCARD = 3'd2,
    HAVE         = 3'd3,
    HALTED       = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic [15:0] w_next_pc;
  logic [15:0] w_pc_inc;
  logic [15:0] w_redirect_pc;
  logic        w_capture;
  logic        w_en;
  logic [15:0] w_addr;
  logic        w_valid;

  assign w_pc_inc      = r_pc + 16'd2;
  assign w_redirect_pc = {bus.redirect_pc_in[15:1], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= REQ;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      if (w_capture) begin
        r_instr <= bus.imem_data_in;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_capture    = 1'b0;
    w_en         = 1'b0;
    w_addr       = r_pc;
    case (r_state)
      REQ: begin
        if (bus.redirect_in) begin
          w_next_pc = w_redirect_pc;
        end else begin
          w_en = 1'b1;
          if (bus.imem_done_in) begin
            w_capture    = 1'b1;
            w_next_state = HAVE;
          end else begin
            w_next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.redirect_in) begin
          // The in-flight response belongs to the old path: drop it, or
          // remember to drop it when it eventually arrives.
          w_next_pc    = w_redirect_pc;
          w_next_state = bus.imem_done_in ? REQ : WAIT_DISCARD;
        end else if (bus.imem_done_in) begin
          w_capture    = 1'b1;
          w_next_state = HAVE;
        end
      end
      WAIT_DISCARD: begin
        if (bus.redirect_in) begin
          w_next_pc = w_redirect_pc;
        end
        if (bus.imem_done_in) begin
          w_next_state = REQ;
        end
      end
      HAVE: begin
        if (bus.redirect_in) begin
          w_next_pc    = w_redirect_pc;
          w_next_state = REQ;
        end else if (bus.pc_write_en_in) begin
          w_next_pc = w_pc_inc;
          if (r_instr == HALT_INSTR) begin
            w_next_state = HALTED;
          end else begin
            // Request the successor in the consume cycle so a zero-latency
            // memory sustains one instruction per cycle.
            w_en   = 1'b1;
            w_addr = w_pc_inc;
            if (bus.imem_done_in) begin
              w_capture = 1'b1;
            end else begin
              w_next_state = WAIT;
            end
          end
        end
      end
      HALTED: begin
        if (bus.redirect_in) begin
          w_next_pc    = w_redirect_pc;
          w_next_state = REQ;
        end
      end
      default: begin
        w_next_state = REQ;
      end
    endcase
  end

  // Outputs are forced to their idle values while rst is held, whatever
  // state the registers happen to contain.
  assign w_valid          = (r_state == HAVE) && !rst;
  assign bus.imem_en_out  = w_en && !rst;
  assign bus.imem_addr_out = w_addr;
  assign bus.valid_out    = w_valid;
  assign bus.instr_out    = w_valid ? r_instr : NOP_INSTR;
  assign bus.pc_plus2_out = w_pc_inc;
  assign bus.halted_out   = (r_state == HALTED) && !rst;

`ifdef FETCH_PERF_EN
  logic [15:0] r_perf_fetched;
  logic [15:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched <= 16'h0000;
      r_perf_stall   <= 16'h0000;
    end else begin
      if (r_state == HAVE && bus.pc_write_en_in && !bus.redirect_in &&
          r_perf_fetched != 16'hFFFF) begin
        r_perf_fetched <= r_perf_fetched + 16'd1;
      end
      if (r_state == HAVE && !bus.pc_write_en_in && r_perf_stall != 16'hFFFF) begin
        r_perf_stall <= r_perf_stall + 16'd1;
      end
    end
  end

  assign perf_fetched_out = r_perf_fetched;
  assign perf_stall_out   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   lat = 0;

  fetch_unit_if bus();

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_stall;
`endif

  fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched_out(perf_fetched),
    .perf_stall_out(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory model: word-indexed, fixed latency in cycles (0 = same cycle).
  logic [15:0] mem [0:32767];
  logic        m_busy;
  int          m_cnt;
  logic [15:0] m_addr;
  logic [15:0] m_sel;
  logic        m_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_addr <= 16'h0000;
    end else if (bus.imem_en_out && lat != 0) begin
      m_busy <= 1'b1;
      m_cnt  <= lat - 1;
      m_addr <= bus.imem_addr_out;
    end else if (m_busy) begin
      if (m_cnt == 0) m_busy <= 1'b0;
      else m_cnt <= m_cnt - 1;
    end
  end

  always_comb begin
    m_sel  = (lat == 0) ? bus.imem_addr_out : m_addr;
    m_done = (lat == 0) ? bus.imem_en_out : (m_busy && m_cnt == 0);
    bus.imem_done_in = m_done;
    bus.imem_data_in = m_done ? mem[m_sel[15:1]] : 16'hDEAD;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    mem[2] = 16'h3333;
    mem[3] = 16'h4444;
    mem[4] = 16'h0000;

    bus.pc_write_en_in = 1'b1;
    bus.redirect_in    = 1'b0;
    bus.redirect_pc_in = 16'h0000;

    // reset state
    tick(); settle();
    chk("rst_en", 16'(bus.imem_en_out), 16'h0);
    chk("rst_valid", 16'(bus.valid_out), 16'h0);
    chk("rst_instr", bus.instr_out, 16'h0800);
    chk("rst_halted", 16'(bus.halted_out), 16'h0);

    // zero-latency streaming
    tick(); rst = 1'b0; settle();
    chk("a0_en", 16'(bus.imem_en_out), 16'h1);
    chk("a0_addr", bus.imem_addr_out, 16'h0000);
    chk("a0_valid", 16'(bus.valid_out), 16'h0);
    tick(); settle();
    chk("a1_valid", 16'(bus.valid_out), 16'h1);
    chk("a1_instr", bus.instr_out, 16'h1111);
    chk("a1_pc2", bus.pc_plus2_out, 16'h0002);
    chk("a1_addr", bus.imem_addr_out, 16'h0002);

    // stall for 4 cycles while presenting 0x2222
    tick(); bus.pc_write_en_in = 1'b0; settle();
    chk("st_instr", bus.instr_out, 16'h2222);
    chk("st_pc2", bus.pc_plus2_out, 16'h0004);
    chk("st_en", 16'(bus.imem_en_out), 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      chk("st_hold_instr", bus.instr_out, 16'h2222);
      chk("st_hold_pc2", bus.pc_plus2_out, 16'h0004);
      chk("st_hold_en", 16'(bus.imem_en_out), 16'h0);
      chk("st_hold_valid", 16'(bus.valid_out), 16'h1);
    end
    tick(); bus.pc_write_en_in = 1'b1; settle();
    chk("rel_en", 16'(bus.imem_en_out), 16'h1);
    chk("rel_addr", bus.imem_addr_out, 16'h0004);
    chk("rel_instr", bus.instr_out, 16'h2222);

    // switch to 3-cycle latency; request to 0x0006 issued here
    tick(); lat = 3; settle();
    chk("a7_instr", bus.instr_out, 16'h3333);
    chk("a7_pc2", bus.pc_plus2_out, 16'h0006);
    chk("a7_en", 16'(bus.imem_en_out), 16'h1);
    chk("a7_addr", bus.imem_addr_out, 16'h0006);
    tick(); settle();
    chk("w1_en", 16'(bus.imem_en_out), 16'h0);
    chk("w1_valid", 16'(bus.valid_out), 16'h0);
    chk("w1_instr", bus.instr_out, 16'h0800);

    // redirect to 0x0041 while the 0x0006 request is pending
    tick(); bus.redirect_in = 1'b1; bus.redirect_pc_in = 16'h0041; settle();
    chk("rd_en", 16'(bus.imem_en_out), 16'h0);
    chk("rd_valid", 16'(bus.valid_out), 16'h0);
    tick(); bus.redirect_in = 1'b0; settle();
    chk("late_valid", 16'(bus.valid_out), 16'h0);
    chk("late_instr", bus.instr_out, 16'h0800);
    chk("late_en", 16'(bus.imem_en_out), 16'h0);
    tick(); settle();
    chk("rq40_en", 16'(bus.imem_en_out), 16'h1);
    chk("rq40_addr", bus.imem_addr_out, 16'h0040);
    chk("rq40_valid", 16'(bus.valid_out), 16'h0);
    tick(); settle();
    chk("l1_en", 16'(bus.imem_en_out), 16'h0);
    tick(); settle();
    chk("l2_en", 16'(bus.imem_en_out), 16'h0);
    chk("l2_valid", 16'(bus.valid_out), 16'h0);
    tick(); settle();
    chk("done_valid", 16'(bus.valid_out), 16'h0);
    tick(); settle();
    chk("after_valid", 16'(bus.valid_out), 16'h1);
    chk("after_instr", bus.instr_out, 16'h1020);
    chk("after_pc2", bus.pc_plus2_out, 16'h0042);

    // redirect to 0x0008 (HALT) from HAVE, zero latency
    lat = 0; bus.redirect_in = 1'b1; bus.redirect_pc_in = 16'h0008; settle();
    chk("rdh_en", 16'(bus.imem_en_out), 16'h0);
    tick(); bus.redirect_in = 1'b0; settle();
    chk("h_req_en", 16'(bus.imem_en_out), 16'h1);
    chk("h_req_addr", bus.imem_addr_out, 16'h0008);
    tick(); settle();
    chk("h_valid", 16'(bus.valid_out), 16'h1);
    chk("h_instr", bus.instr_out, 16'h0000);
    chk("h_en", 16'(bus.imem_en_out), 16'h0);
    tick(); settle();
    chk("hd_halted", 16'(bus.halted_out), 16'h1);
    chk("hd_en", 16'(bus.imem_en_out), 16'h0);
    chk("hd_valid", 16'(bus.valid_out), 16'h0);
    tick(); settle();
    chk("hd2_en", 16'(bus.imem_en_out), 16'h0);
    chk("hd2_halted", 16'(bus.halted_out), 16'h1);
    bus.redirect_in = 1'b1; bus.redirect_pc_in = 16'h0010; settle();
    chk("hd_rd_en", 16'(bus.imem_en_out), 16'h0);
    tick(); bus.redirect_in = 1'b0; settle();
    chk("res_halted", 16'(bus.halted_out), 16'h0);
    chk("res_en", 16'(bus.imem_en_out), 16'h1);
    chk("res_addr", bus.imem_addr_out, 16'h0010);
    tick(); settle();
    chk("res_valid", 16'(bus.valid_out), 16'h1);
    chk("res_instr", bus.instr_out, 16'h1008);

    // wrap at 0xFFFE
    bus.redirect_in = 1'b1; bus.redirect_pc_in = 16'hFFFE; settle();
    tick(); bus.redirect_in = 1'b0; settle();
    chk("wr_en", 16'(bus.imem_en_out), 16'h1);
    chk("wr_addr", bus.imem_addr_out, 16'hFFFE);
    tick(); settle();
    chk("wr_instr", bus.instr_out, 16'h8FFF);
    chk("wr_pc2", bus.pc_plus2_out, 16'h0000);
    chk("wr_next_addr", bus.imem_addr_out, 16'h0000);
    chk("wr_next_en", 16'(bus.imem_en_out), 16'h1);
    tick(); lat = 3; settle();
    chk("wr0_instr", bus.instr_out, 16'h1111);
    chk("wr0_addr", bus.imem_addr_out, 16'h0002);
    chk("wr0_en", 16'(bus.imem_en_out), 16'h1);

    // reset in the middle of WAIT
    tick(); rst = 1'b1; settle();
    chk("mrst_en", 16'(bus.imem_en_out), 16'h0);
    chk("mrst_valid", 16'(bus.valid_out), 16'h0);
    chk("mrst_instr", bus.instr_out, 16'h0800);
    chk("mrst_halted", 16'(bus.halted_out), 16'h0);
    tick(); rst = 1'b0; lat = 0; settle();
    chk("pr_en", 16'(bus.imem_en_out), 16'h1);
    chk("pr_addr", bus.imem_addr_out, 16'h0000);
    chk("pr_valid", 16'(bus.valid_out), 16'h0);
    tick(); settle();
    chk("pr_valid2", 16'(bus.valid_out), 16'h1);
    chk("pr_instr", bus.instr_out, 16'h1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
